// File: rtl/turn_ctrl.sv
// Turn-signal input conditioner: synchronizes and debounces the left/right/hazard
// switches, resolves the lamp mode and paces both tail-light sequencers.
module turn_ctrl #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TICK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic [1:0] mode,
  output logic       left_in,
  output logic       right_in,
  output logic       step,
  output logic       seq_clr
);

  localparam int unsigned DW = $clog2(DEBOUNCE) + 1;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned NREQ = 3;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } mode_e;

  // Bit order: [0] left, [1] right, [2] hazard.
  logic [NREQ-1:0] raw;
  logic [NREQ-1:0] sync1;
  logic [NREQ-1:0] sync2;
  logic [NREQ-1:0] deb;
  logic [DW-1:0]   db_cnt [NREQ];
  logic [TW-1:0]   tick;
  mode_e           mode_q;
  mode_e           mode_d;
  logic            mode_chg;

  assign raw = {hazard_req, right_req, left_req};

  // Two-flop synchronizer on each raw switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounced value follows only after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < int'(NREQ); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Priority resolution; left+right together is treated as hazard.
  always_comb begin
    mode_d = IDLE;
    if (deb[2] || (deb[0] && deb[1])) begin
      mode_d = HAZARD;
    end else if (deb[0]) begin
      mode_d = LEFT;
    end else if (deb[1]) begin
      mode_d = RIGHT;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  // Mode register, restart pulse and step pacing counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= IDLE;
      seq_clr <= 1'b0;
      tick    <= '0;
    end else begin
      mode_q  <= mode_d;
      seq_clr <= mode_chg;
      if (mode_chg || (mode_q == IDLE) || (tick == TICK_MAX)) begin
        tick <= '0;
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

  assign mode     = mode_q;
  assign left_in  = (mode_q == LEFT)  || (mode_q == HAZARD);
  assign right_in = (mode_q == RIGHT) || (mode_q == HAZARD);
  assign step     = (mode_q != IDLE) && (tick == TICK_MAX);

endmodule
